// File: rtl/button_pulse_conditioner.sv
// Conditions raw pushbuttons into debounced levels and single-cycle press pulses,
// with optional hold-to-auto-repeat. Each channel is independent.
module button_pulse_conditioner #(
  parameter int N_BTN               = 2,
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_EN           = 1,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RATE  = 2'd2,
    HELD  = 2'd3
  } state_t;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             pulse_q, pulse_d;
    state_t           state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        stable_q  <= 1'b0;
        db_cnt_q  <= '0;
        rpt_cnt_q <= '0;
        pulse_q   <= 1'b0;
        state_q   <= IDLE;
      end else begin
        sync1_q   <= btn_raw[g];
        sync2_q   <= sync1_q;
        stable_q  <= stable_d;
        db_cnt_q  <= db_cnt_d;
        rpt_cnt_q <= rpt_cnt_d;
        pulse_q   <= pulse_d;
        state_q   <= state_d;
      end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      if (sync2_q != stable_q) begin
        if (db_cnt_q == DB_LAST) begin
          stable_d = sync2_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // FSM keys off the next debounced level so the press pulse lines up with btn_level.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      pulse_d   = 1'b0;
      if (!stable_d) begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!stable_q) begin
              pulse_d   = 1'b1;
              rpt_cnt_d = '0;
              state_d   = (REPEAT_EN != 0) ? DELAY : HELD;
            end
          end
          DELAY: begin
            if (rpt_cnt_q == DELAY_LAST) begin
              pulse_d   = 1'b1;
              rpt_cnt_d = '0;
              state_d   = RATE;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
          end
          RATE: begin
            if (rpt_cnt_q == RATE_LAST) begin
              pulse_d   = 1'b1;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
          end
          HELD: begin
            pulse_d = 1'b0;
          end
          default: begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end

    assign btn_pulse[g] = pulse_q;
    assign btn_level[g] = stable_q;
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner: a repeat-enabled and a repeat-disabled instance
// share one raw input and are checked every cycle against a timestamp-based model.
module tb_button_pulse_conditioner;

  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int RAT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] pulse_a, lvl_a, pulse_b, lvl_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  button_pulse_conditioner #(
    .N_BTN(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY_CYCLES(DLY), .REPEAT_RATE_CYCLES(RAT)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_pulse(pulse_a), .btn_level(lvl_a)
  );

  button_pulse_conditioner #(
    .N_BTN(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY_CYCLES(DLY), .REPEAT_RATE_CYCLES(RAT)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_pulse(pulse_b), .btn_level(lvl_b)
  );

  // Reference model: index [m][c], m=0 repeat instance, m=1 single-pulse instance.
  logic [1:0] r1, r2;
  int         edge_n = 0;
  bit         m_lvl      [2][2];
  bit         m_pulse    [2][2];
  int         diff_start [2][2];
  int         t_rise     [2][2];
  int         pc         [2][2];
  logic [1:0] seen_lvl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
  endtask

  task automatic model_reset();
    r1 = '0;
    r2 = '0;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) begin
        m_lvl[m][c]      = 1'b0;
        m_pulse[m][c]    = 1'b0;
        diff_start[m][c] = -1;
        t_rise[m][c]     = 0;
      end
  endtask

  task automatic model_step(input logic [1:0] raw_now);
    logic [1:0] s;
    bit         rose;
    int         dt;
    s  = r2;
    r2 = r1;
    r1 = raw_now;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) begin
        rose = 1'b0;
        m_pulse[m][c] = 1'b0;
        if (s[c] == m_lvl[m][c]) begin
          diff_start[m][c] = -1;
        end else begin
          if (diff_start[m][c] < 0) diff_start[m][c] = edge_n;
          if (edge_n - diff_start[m][c] == DEB - 1) begin
            m_lvl[m][c]      = s[c];
            diff_start[m][c] = -1;
            if (s[c]) begin
              rose         = 1'b1;
              t_rise[m][c] = edge_n;
            end
          end
        end
        if (rose) begin
          m_pulse[m][c] = 1'b1;
        end else if (m_lvl[m][c] && m == 0) begin
          dt = edge_n - t_rise[m][c];
          m_pulse[m][c] = (dt >= DLY) && ((dt - DLY) % RAT == 0);
        end
      end
  endtask

  task automatic compare_all();
    logic [1:0] ep_a, el_a, ep_b, el_b;
    for (int c = 0; c < 2; c++) begin
      ep_a[c] = m_pulse[0][c];
      el_a[c] = m_lvl[0][c];
      ep_b[c] = m_pulse[1][c];
      el_b[c] = m_lvl[1][c];
    end
    check("a_pulse", 32'(pulse_a), 32'(ep_a));
    check("a_level", 32'(lvl_a),   32'(el_a));
    check("b_pulse", 32'(pulse_b), 32'(ep_b));
    check("b_level", 32'(lvl_b),   32'(el_b));
  endtask

  task automatic clear_counts();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++) pc[m][c] = 0;
    seen_lvl = '0;
  endtask

  task automatic tick();
    logic [1:0] raw_now;
    raw_now = btn_raw;
    @(posedge clk);
    edge_n++;
    if (!rst_n) model_reset();
    else model_step(raw_now);
    #1;
    compare_all();
    for (int c = 0; c < 2; c++) begin
      pc[0][c] += int'(pulse_a[c]);
      pc[1][c] += int'(pulse_b[c]);
    end
    seen_lvl = seen_lvl | lvl_a | lvl_b;
  endtask

  typedef struct {
    logic [1:0] raw;
    int         hold;
    logic [1:0] level;
    int         a0, a1, b0, b1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int first_edge;
    logic [1:0] first_val;

    vecs[0] = '{2'b00, 10, 2'b00, 0, 0, 0, 0};
    vecs[1] = '{2'b01, 10, 2'b01, 1, 0, 1, 0};
    vecs[2] = '{2'b00, 10, 2'b00, 0, 0, 0, 0};  // release coincides with first repeat
    vecs[3] = '{2'b11, 30, 2'b11, 6, 6, 1, 1};
    vecs[4] = '{2'b01, 12, 2'b01, 4, 2, 0, 0};
    vecs[5] = '{2'b00, 12, 2'b00, 2, 0, 0, 0};

    rst_n   = 1'b0;
    btn_raw = 2'b00;
    model_reset();
    #1;
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      btn_raw = vecs[i].raw;
      clear_counts();
      repeat (vecs[i].hold) tick();
      check($sformatf("vec%0d_level_a", i), 32'(lvl_a), 32'(vecs[i].level));
      check($sformatf("vec%0d_level_b", i), 32'(lvl_b), 32'(vecs[i].level));
      check($sformatf("vec%0d_a0_pulses", i), 32'(pc[0][0]), 32'(vecs[i].a0));
      check($sformatf("vec%0d_a1_pulses", i), 32'(pc[0][1]), 32'(vecs[i].a1));
      check($sformatf("vec%0d_b0_pulses", i), 32'(pc[1][0]), 32'(vecs[i].b0));
      check($sformatf("vec%0d_b1_pulses", i), 32'(pc[1][1]), 32'(vecs[i].b1));
    end

    // Bounce shorter than the debounce window must vanish.
    clear_counts();
    btn_raw = 2'b01; tick();
    btn_raw = 2'b00; tick();
    btn_raw = 2'b01; tick();
    btn_raw = 2'b00;
    repeat (10) tick();
    check("bounce_level", 32'(seen_lvl), 32'd0);
    check("bounce_pulses", 32'(pc[0][0] + pc[1][0]), 32'd0);

    // Both buttons on the same edge, then asynchronous reset mid-hold.
    btn_raw    = 2'b11;
    first_edge = -1;
    first_val  = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (first_edge < 0 && pulse_a != 2'b00) begin
        first_edge = k;
        first_val  = pulse_a;
      end
    end
    check("both_first_edge", 32'(first_edge), 32'd6);
    check("both_first_val",  32'(first_val),  32'd3);

    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_level", 32'({lvl_a, lvl_b}), 32'd0);
    check("async_rst_pulse", 32'({pulse_a, pulse_b}), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    clear_counts();
    first_edge = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (first_edge < 0 && pulse_a[0]) first_edge = k;
    end
    check("post_rst_edge", 32'(first_edge), 32'd6);
    check("post_rst_count", 32'(pc[0][0]), 32'd1);

    // Random press patterns against the model.
    for (int i = 0; i < 60; i++) begin
      btn_raw = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 14)) tick();
    end
    btn_raw = 2'b00;
    repeat (20) tick();
    check("final_idle_level", 32'({lvl_a, lvl_b}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
